// File: rtl/regfile_pkg.sv
// Shared constants for the RegisterFile sequencer: FunSel codes, command opcodes,
// FSM state encoding and small opcode classification helpers.
package regfile_pkg;

    localparam logic [2:0] FUN_DEC  = 3'b000;
    localparam logic [2:0] FUN_INC  = 3'b001;
    localparam logic [2:0] FUN_LOAD = 3'b010;
    localparam logic [2:0] FUN_CLR  = 3'b011;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_CLR  = 3'd1;
    localparam logic [2:0] OP_INC  = 3'd2;
    localparam logic [2:0] OP_DEC  = 3'd3;
    localparam logic [2:0] OP_LDI  = 3'd4;
    localparam logic [2:0] OP_MOV  = 3'd5;
    localparam logic [2:0] OP_SWAP = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_WR1  = 3'd2,
        S_WR2  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    function automatic logic op_is_swap(input logic [2:0] op, input logic swap_en);
        return (op == OP_SWAP) && swap_en;
    endfunction

    // MOV and a supported SWAP need the registered OutA/OutB, so they pass through READ.
    function automatic logic op_reads(input logic [2:0] op, input logic swap_en);
        return (op == OP_MOV) || op_is_swap(op, swap_en);
    endfunction

    function automatic logic op_illegal(input logic [2:0] op, input logic swap_en);
        return (op == OP_ILL) || ((op == OP_SWAP) && !swap_en);
    endfunction

endpackage

// File: rtl/rf_index_decode.sv
// Maps a 3-bit register index (0-3 = R1-R4, 4-7 = S1-S4) onto the one-hot
// RegSel/ScrSel pair; bit 3 selects R1/S1, bit 0 selects R4/S4.
module rf_index_decode (
    input  logic [2:0] idx,
    output logic [3:0] reg_sel,
    output logic [3:0] scr_sel
);

    logic [3:0] onehot;

    assign onehot  = 4'b1000 >> idx[1:0];
    assign reg_sel = idx[2] ? 4'b0000 : onehot;
    assign scr_sel = idx[2] ? onehot  : 4'b0000;

endmodule

// File: rtl/regfile_sequencer.sv
// Command-driven initiator for the 8-entry RegisterFile: accepts one register-level
// command per handshake and sequences the read/write cycles needed to execute it.
module regfile_sequencer
    import regfile_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter bit SWAP_EN = 1'b1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [2:0]        cmd_src,
    input  logic [2:0]        cmd_dst,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rf_I,
    output logic [2:0]        rf_FunSel,
    output logic [3:0]        rf_RegSel,
    output logic [3:0]        rf_ScrSel,
    output logic [2:0]        rf_OutASel,
    output logic [2:0]        rf_OutBSel,
    input  logic [DATA_W-1:0] rf_OutA,
    input  logic [DATA_W-1:0] rf_OutB
);

    state_t            state, next_state;
    logic              run;
    logic [2:0]        op_p0, src_p0, dst_p0;
    logic [DATA_W-1:0] imm_p0;
    logic [DATA_W-1:0] hold_p1;
    logic [2:0]        asel_q, bsel_q;
    logic [3:0]        dst_reg_sel, dst_scr_sel, src_reg_sel, src_scr_sel;
    logic              accept;

    rf_index_decode u_dst_decode (.idx(dst_p0), .reg_sel(dst_reg_sel), .scr_sel(dst_scr_sel));
    rf_index_decode u_src_decode (.idx(src_p0), .reg_sel(src_reg_sel), .scr_sel(src_scr_sel));

    // run keeps cmd_ready low while Reset is held and for the first edge after it
    assign cmd_ready = run && (state == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
            run   <= 1'b0;
        end else begin
            state <= next_state;
            run   <= 1'b1;
        end
    end

    // Command latch, SWAP hold register and the sticky read selects
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            op_p0   <= '0;
            src_p0  <= '0;
            dst_p0  <= '0;
            imm_p0  <= '0;
            hold_p1 <= '0;
            asel_q  <= '0;
            bsel_q  <= '0;
        end else begin
            if (accept) begin
                op_p0  <= cmd_op;
                src_p0 <= cmd_src;
                dst_p0 <= cmd_dst;
                imm_p0 <= cmd_imm;
            end
            if (state == S_READ) begin
                asel_q <= src_p0;
                bsel_q <= dst_p0;
            end
            if (state == S_WR1) begin
                hold_p1 <= rf_OutB;
            end
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: if (accept) next_state = op_reads(cmd_op, SWAP_EN) ? S_READ : S_WR1;
            S_READ: next_state = S_WR1;
            S_WR1:  next_state = op_is_swap(op_p0, SWAP_EN) ? S_WR2 : S_DONE;
            S_WR2:  next_state = S_DONE;
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        rf_I       = '0;
        rf_FunSel  = FUN_DEC;
        rf_RegSel  = 4'b0000;
        rf_ScrSel  = 4'b0000;
        rf_OutASel = asel_q;
        rf_OutBSel = bsel_q;
        done       = 1'b0;
        err        = 1'b0;
        unique case (state)
            S_READ: begin
                rf_OutASel = src_p0;
                rf_OutBSel = dst_p0;
            end
            S_WR1: begin
                if (!op_illegal(op_p0, SWAP_EN) && (op_p0 != OP_NOP)) begin
                    rf_RegSel = dst_reg_sel;
                    rf_ScrSel = dst_scr_sel;
                end
                unique case (op_p0)
                    OP_CLR:  rf_FunSel = FUN_CLR;
                    OP_INC:  rf_FunSel = FUN_INC;
                    OP_DEC:  rf_FunSel = FUN_DEC;
                    OP_LDI: begin
                        rf_FunSel = FUN_LOAD;
                        rf_I      = imm_p0;
                    end
                    OP_MOV, OP_SWAP: begin
                        rf_FunSel = FUN_LOAD;
                        rf_I      = rf_OutA;
                    end
                    default: rf_FunSel = FUN_DEC;
                endcase
            end
            // Second half of SWAP: old dst value captured from OutB goes back to src
            S_WR2: begin
                rf_FunSel = FUN_LOAD;
                rf_I      = hold_p1;
                rf_RegSel = src_reg_sel;
                rf_ScrSel = src_scr_sel;
            end
            S_DONE: begin
                done = 1'b1;
                err  = op_illegal(op_p0, SWAP_EN);
            end
            default: ;
        endcase
    end

endmodule
